// File: rtl/dmem_bridge.sv
// Data-memory bridge: turns a single-cycle mem-stage request into a held bus
// cycle. It stalls the pipeline until ack or timeout, then returns load data.
module dmem_bridge #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        flush_i,
    output logic [31:0] rdata_o,
    output logic        stall_req_o,
    output logic        bus_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam logic       CHIP_ENABLE = 1'b1;
    localparam logic [7:0] LAST_WAIT   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] wait_cnt;
    logic       capture;
    logic       ack_seen;
    logic       timed_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next  = state;
        capture     = 1'b0;
        ack_seen    = 1'b0;
        timed_out   = 1'b0;
        stall_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (ce_i == CHIP_ENABLE && !flush_i) begin
                    capture     = 1'b1;
                    stall_req_o = 1'b1;
                    state_next  = BUSY;
                end
            end
            BUSY: begin
                stall_req_o = 1'b1;
                // Ack has priority over a timeout landing in the same cycle.
                if (bus_ack_i) begin
                    ack_seen   = 1'b1;
                    state_next = DONE;
                end else if (wait_cnt == LAST_WAIT) begin
                    timed_out  = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        // The request term looks at ce_i directly, so it must be masked while in reset.
        if (rst) begin
            stall_req_o = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt    <= '0;
            rdata_o     <= '0;
            bus_err_o   <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
        end else begin
            bus_err_o <= timed_out;
            if (capture) begin
                bus_req_o   <= 1'b1;
                bus_we_o    <= we_i;
                bus_sel_o   <= sel_i;
                bus_addr_o  <= addr_i;
                bus_wdata_o <= wdata_i;
                wait_cnt    <= '0;
            end else if (ack_seen) begin
                bus_req_o <= 1'b0;
                bus_we_o  <= 1'b0;
                if (!bus_we_o) begin
                    rdata_o <= bus_rdata_i;
                end
            end else if (timed_out) begin
                bus_req_o <= 1'b0;
                bus_we_o  <= 1'b0;
                if (!bus_we_o) begin
                    rdata_o <= '0;
                end
            end else if (state == BUSY) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end

    a_busy_stable : assert property (@(posedge clk) disable iff (rst)
        (state == BUSY && state_next == BUSY) |=>
            ($stable(bus_addr_o) && $stable(bus_sel_o) && $stable(bus_wdata_o)
             && $stable(bus_we_o) && bus_req_o));

    a_err_in_done : assert property (@(posedge clk) disable iff (rst)
        bus_err_o |-> (state == DONE));

    a_we_needs_req : assert property (@(posedge clk) disable iff (rst)
        bus_we_o |-> bus_req_o);

endmodule
